// File: rtl/afifo_arb_pkg.sv
// Shared types and helpers for the async-FIFO write-side arbiter.
`ifndef DATA_WIDTH
`define DATA_WIDTH 16
`endif

package afifo_arb_pkg;

   typedef enum logic {IDLE, BURST} arb_state_e;

   localparam int CNT_W = 16;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

endpackage

// File: rtl/afifo_wr_arbiter_if.sv
// Producer handshake plus FIFO write port seen by the write-side arbiter.
interface afifo_wr_arbiter_if #(
   parameter int NUM_REQ    = 4,
   parameter int DATA_WIDTH = `DATA_WIDTH
);
   logic [NUM_REQ-1:0]                 req_valid;
   logic [NUM_REQ-1:0][DATA_WIDTH-1:0] req_data;
   logic [NUM_REQ-1:0]                 req_ready;
   logic                               wfull;
   logic                               winc;
   logic [DATA_WIDTH-1:0]              wdata;

   // master drives producers and the FIFO full flag; slave is the arbiter
   modport master (output req_valid, req_data, wfull, input req_ready, winc, wdata);
   modport slave  (input req_valid, req_data, wfull, output req_ready, winc, wdata);
endinterface

// File: rtl/afifo_rr_picker.sv
// Rotate-priority picker: first valid index at or after rr_ptr, wrapping.
module afifo_rr_picker #(
   parameter int NUM_REQ = 4
) (
   input  logic [NUM_REQ-1:0]         req_valid,
   input  logic [$clog2(NUM_REQ)-1:0] rr_ptr,
   output logic [NUM_REQ-1:0]         sel,
   output logic                       any
);
   localparam int PTR_W = $clog2(NUM_REQ);
   localparam logic [PTR_W:0] NREQ = (PTR_W+1)'(NUM_REQ);

   logic [PTR_W:0] pos;

   // walk from farthest to nearest so the closest valid index wins
   always_comb begin
      sel = '0;
      pos = '0;
      for (int k = NUM_REQ-1; k >= 0; k--) begin
         pos = {1'b0, rr_ptr} + (PTR_W+1)'(k);
         if (pos >= NREQ) pos = pos - NREQ;
         if (req_valid[pos[PTR_W-1:0]]) begin
            sel = '0;
            sel[pos[PTR_W-1:0]] = 1'b1;
         end
      end
   end

   assign any = |req_valid;
endmodule

// File: rtl/afifo_wr_arbiter.sv
// Round-robin burst arbiter sharing the async FIFO write port among producers.
module afifo_wr_arbiter
   import afifo_arb_pkg::*;
#(
   parameter int NUM_REQ    = 4,
   parameter int DATA_WIDTH = `DATA_WIDTH,
   parameter int MAX_BURST  = 4
) (
   input  logic                 wclk,
   input  logic                 wrst,
   afifo_wr_arbiter_if.slave    bus,
   output logic [NUM_REQ-1:0]   grant,
   output logic                 busy,
   output logic [CNT_W-1:0]     wr_count,
   output logic [CNT_W-1:0]     stall_count
);
   localparam int PTR_W = $clog2(NUM_REQ);
   localparam int BC_W  = $clog2(MAX_BURST+1);
   localparam logic [BC_W-1:0]  LAST_BEAT = BC_W'(MAX_BURST-1);
   localparam logic [PTR_W-1:0] LAST_IDX  = PTR_W'(NUM_REQ-1);

   arb_state_e             state, state_nxt;
   logic [PTR_W-1:0]       rr_ptr, gidx, pick_idx;
   logic [NUM_REQ-1:0]     pick_sel;
   logic                   pick_any;
   logic [BC_W-1:0]        beat_cnt;
   logic                   wfull_q;
   logic                   own_vld, ok, done;
   logic [DATA_WIDTH-1:0]  own_data;

   afifo_rr_picker #(.NUM_REQ(NUM_REQ)) u_pick (
      .req_valid (bus.req_valid),
      .rr_ptr    (rr_ptr),
      .sel       (pick_sel),
      .any       (pick_any)
   );

   always_comb begin
      pick_idx = '0;
      for (int i = 0; i < NUM_REQ; i++)
         if (pick_sel[i]) pick_idx = PTR_W'(i);
   end

   assign own_vld  = bus.req_valid[gidx];
   assign own_data = bus.req_data[gidx];
   // wfull_q covers the cycle after full drops, when the FIFO flag may still lag
   assign ok   = (state == BURST) & own_vld & ~bus.wfull & ~wfull_q & ~wrst;
   assign done = (state == BURST) & (~own_vld | (ok & (beat_cnt == LAST_BEAT)));

   always_ff @(posedge wclk) begin
      if (wrst) state <= IDLE;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (pick_any) state_nxt = BURST;
         BURST:   if (done)     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      busy          = (state == BURST);
      bus.winc      = ok;
      bus.req_ready = '0;
      if (ok) bus.req_ready[gidx] = 1'b1;
      bus.wdata     = ((|grant) && !wrst) ? own_data : '0;
   end

   always_ff @(posedge wclk) begin
      if (wrst) begin
         grant       <= '0;
         gidx        <= '0;
         rr_ptr      <= '0;
         beat_cnt    <= '0;
         wfull_q     <= 1'b0;
         wr_count    <= '0;
         stall_count <= '0;
      end else begin
         wfull_q <= bus.wfull;
         if (state == IDLE && pick_any) begin
            grant    <= pick_sel;
            gidx     <= pick_idx;
            beat_cnt <= '0;
         end else begin
            if (ok) beat_cnt <= beat_cnt + 1'b1;
            if (done) begin
               grant  <= '0;
               rr_ptr <= (gidx == LAST_IDX) ? '0 : gidx + 1'b1;
            end
         end
         if (ok) wr_count <= sat_inc(wr_count);
         if (busy & own_vld & ~ok) stall_count <= sat_inc(stall_count);
      end
   end
endmodule

// File: tb/tb_afifo_wr_arbiter.sv
// Scoreboard bench: producer queues feed expected beats, a monitor checks every write.
module tb_afifo_wr_arbiter;
   localparam int NR = 4;
   localparam int DW = 16;
   localparam int MB = 4;

   logic wclk = 1'b0;
   logic wrst = 1'b1;
   logic srst = 1'b1;
   always #5 wclk = ~wclk;

   afifo_wr_arbiter_if #(.NUM_REQ(NR), .DATA_WIDTH(DW)) bif ();
   logic [NR-1:0] grant;
   logic          busy;
   logic [15:0]   wr_count, stall_count;

   afifo_wr_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .MAX_BURST(MB)) u_dut (
      .wclk(wclk), .wrst(wrst), .bus(bif.slave), .grant(grant), .busy(busy),
      .wr_count(wr_count), .stall_count(stall_count));

   // second instance dedicated to counter saturation
   afifo_wr_arbiter_if #(.NUM_REQ(2), .DATA_WIDTH(DW)) sif ();
   logic [1:0]  sat_grant;
   logic        sat_busy;
   logic [15:0] sat_wr, sat_stall;

   afifo_wr_arbiter #(.NUM_REQ(2), .DATA_WIDTH(DW), .MAX_BURST(16)) u_sat (
      .wclk(wclk), .wrst(srst), .bus(sif.slave), .grant(sat_grant), .busy(sat_busy),
      .wr_count(sat_wr), .stall_count(sat_stall));

   int total = 0;
   int bad   = 0;

   function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
      end
   endfunction

   // producer model
   int             left [NR];
   int             seq  [NR];
   bit             pres [NR];
   bit             rnd_mode = 1'b0;
   logic [DW-1:0]  exp_q [NR][$];

   logic [NR-1:0]  s_ready, s_grant, prev_g;
   logic           s_winc, s_busy;
   logic [15:0]    s_wr, s_stall;
   int             g_seq[$];
   int             b_seq[$];

   function automatic logic [DW-1:0] mkdata(input int i, input int s);
      return DW'(i * 4096 + (s % 4096));
   endfunction

   task automatic drive();
      for (int i = 0; i < NR; i++) begin
         if (!pres[i] && left[i] > 0) begin
            exp_q[i].push_back(mkdata(i, seq[i]));
            pres[i] = 1'b1;
         end
         bif.req_valid[i] = pres[i] && (!rnd_mode || $urandom_range(0, 3) != 0);
         bif.req_data[i]  = pres[i] ? mkdata(i, seq[i]) : '0;
      end
   endtask

   // sample the current cycle at negedge, then advance producers after the edge
   task automatic tick();
      @(negedge wclk);
      s_ready = bif.req_ready;
      s_grant = grant;
      s_winc  = bif.winc;
      s_busy  = busy;
      s_wr    = wr_count;
      s_stall = stall_count;
      if (s_grant != 0 && prev_g == 0) begin
         g_seq.push_back(int'(s_grant));
         b_seq.push_back(0);
      end
      if (s_winc && b_seq.size() > 0) b_seq[b_seq.size()-1]++;
      prev_g = s_grant;
      @(posedge wclk);
      #1;
      for (int i = 0; i < NR; i++)
         if (s_ready[i]) begin
            pres[i] = 1'b0;
            seq[i]++;
            left[i]--;
         end
      if (rnd_mode) bif.wfull = ($urandom_range(0, 4) == 0);
      drive();
   endtask

   function automatic bit all_done();
      for (int i = 0; i < NR; i++) if (left[i] != 0) return 1'b0;
      return s_grant == 0;
   endfunction

   task automatic run_idle(input int budget, input string nm);
      int t;
      t = 0;
      do begin
         tick();
         t++;
      end while (!all_done() && t < budget);
      if (!all_done()) chk({nm, "_timeout"}, 0, 1);
   endtask

   // monitor: every write must be the owner's next beat and obey full and burst rules
   logic          prev_wf = 1'b0;
   logic [NR-1:0] mon_prev_g = '0;
   logic [NR-1:0] mon_prev_v = '0;
   int            last_owner = NR-1;
   int            bcnt = 0;

   always @(negedge wclk) begin
      int o, e;
      if (wrst) begin
         chk("rst_winc", bif.winc, 0);
         chk("rst_ready", bif.req_ready, 0);
         chk("rst_wdata", bif.wdata, 0);
         last_owner = NR-1;
      end else begin
         if (grant != 0 && mon_prev_g == 0) begin
            e = -1;
            for (int k = 1; k <= NR; k++)
               if (e < 0 && mon_prev_v[(last_owner + k) % NR]) e = (last_owner + k) % NR;
            chk("rr_pick", grant, (e < 0) ? 0 : (1 << e));
            for (int i = 0; i < NR; i++) if (grant[i]) last_owner = i;
            bcnt = 0;
         end
         if (bif.winc) begin
            bcnt++;
            chk("full_guard", bif.wfull | prev_wf, 0);
            chk("ready_eq_grant", bif.req_ready, grant);
            chk("burst_len", bcnt <= MB, 1);
            o = -1;
            for (int i = 0; i < NR; i++) if (bif.req_ready[i]) o = i;
            if ($countones(bif.req_ready) != 1) chk("ready_onehot", bif.req_ready, 0);
            else if (exp_q[o].size() == 0) chk("unexpected_write", bif.wdata, 0);
            else chk("wdata", bif.wdata, exp_q[o].pop_front());
         end else begin
            chk("ready_idle", bif.req_ready, 0);
         end
      end
      prev_wf    = bif.wfull;
      mon_prev_g = grant;
      mon_prev_v = bif.req_valid;
   end

   // saturation run on the second instance
   bit sat_done = 1'b0;
   initial begin
      int n, cyc;
      sif.req_valid = 2'b11;
      sif.req_data  = {16'h5A5A, 16'hA5A5};
      sif.wfull     = 1'b0;
      repeat (3) @(posedge wclk);
      #1 srst = 1'b0;
      n = 0;
      cyc = 0;
      while (n < 65540 && cyc < 75000) begin
         @(negedge wclk);
         cyc++;
         if (n == 40000 && sif.winc) chk("sat_mid_count", sat_wr, 40000);
         if (sif.winc) n++;
      end
      if (n < 65540) chk("sat_timeout", n, 65540);
      @(negedge wclk);
      chk("sat_wr_count", sat_wr, 16'hFFFF);
      chk("sat_stall", sat_stall, 0);
      sat_done = 1'b1;
   end

   initial begin
      logic [13:0] pat;
      int base, sum;
      bif.req_valid = '0;
      bif.req_data  = '0;
      bif.wfull     = 1'b0;
      prev_g        = '0;
      for (int i = 0; i < NR; i++) begin left[i] = 0; seq[i] = 0; pres[i] = 0; end

      repeat (3) tick();
      chk("rst_grant", s_grant, 0);
      chk("rst_busy", s_busy, 0);
      chk("rst_wr", s_wr, 0);
      wrst = 1'b0;
      tick();
      chk("post_rst_grant", s_grant, 0);
      chk("post_rst_stall", s_stall, 0);

      // all producers busy: strict round robin, full bursts
      g_seq.delete(); b_seq.delete();
      for (int i = 0; i < NR; i++) left[i] = 8;
      drive();
      run_idle(200, "rr");
      chk("rr_ngrants", g_seq.size(), 8);
      for (int k = 0; k < g_seq.size() && k < 8; k++) begin
         chk("rr_order", g_seq[k], 1 << (k % 4));
         chk("rr_beats", b_seq[k], MB);
      end
      chk("rr_wr", s_wr, 32);

      // single producer, 10 beats: 4,4,2 with one idle cycle between bursts
      pat = 14'b01101111011110;
      left[0] = 10;
      drive();
      for (int k = 0; k < 14; k++) begin
         tick();
         chk("single_winc", s_winc, pat[k]);
         if (s_winc) chk("single_grant", s_grant, 4'b0001);
      end
      tick();
      chk("single_wr", s_wr, 42);
      chk("single_stall", s_stall, 0);

      // full for 5 cycles after beat 2 of producer 1
      g_seq.delete(); b_seq.delete();
      left[1] = 4;
      drive();
      for (int t = 0; t < 20 && !(b_seq.size() > 0 && b_seq[0] == 2); t++) tick();
      base = int'(s_stall);
      bif.wfull = 1'b1;
      for (int k = 0; k < 5; k++) begin
         tick();
         chk("full_winc", s_winc, 0);
         chk("full_grant", s_grant, 4'b0010);
      end
      bif.wfull = 1'b0;
      tick();
      chk("full_lag_winc", s_winc, 0);
      tick();
      chk("full_resume", s_winc, 1);
      chk("full_stall", s_stall, base + 6);
      run_idle(50, "full");
      chk("full_ngrants", g_seq.size(), 1);
      if (b_seq.size() > 0) chk("full_beats", b_seq[0], 4);

      // owner 2 drops valid after one beat while 3 waits
      g_seq.delete(); b_seq.delete();
      left[2] = 1;
      left[3] = 4;
      drive();
      for (int t = 0; t < 30 && g_seq.size() < 2; t++) tick();
      left[2] = 3;
      drive();
      run_idle(100, "drop");
      chk("drop_ngrants", g_seq.size(), 3);
      if (g_seq.size() == 3) begin
         chk("drop_g0", g_seq[0], 4'b0100);
         chk("drop_g1", g_seq[1], 4'b1000);
         chk("drop_g2", g_seq[2], 4'b0100);
         chk("drop_b0", b_seq[0], 1);
         chk("drop_b1", b_seq[1], 4);
         chk("drop_b2", b_seq[2], 3);
      end

      // reset during beat 2 of producer 3's burst
      g_seq.delete(); b_seq.delete();
      left[3] = 4;
      drive();
      for (int t = 0; t < 20 && !(b_seq.size() > 0 && b_seq[0] == 1); t++) tick();
      wrst = 1'b1;
      left[0] = 4;
      drive();
      tick();
      chk("rstmid_winc", s_winc, 0);
      chk("rstmid_ready", s_ready, 0);
      wrst = 1'b0;
      tick();
      chk("rstmid_grant", s_grant, 0);
      chk("rstmid_busy", s_busy, 0);
      chk("rstmid_wr", s_wr, 0);
      chk("rstmid_stall", s_stall, 0);
      g_seq.delete(); b_seq.delete();
      run_idle(100, "rstmid");
      chk("rstmid_ngrants", g_seq.size(), 2);
      if (g_seq.size() == 2) begin
         chk("rstmid_g0", g_seq[0], 4'b0001);
         chk("rstmid_g1", g_seq[1], 4'b1000);
         chk("rstmid_b1", b_seq[1], 3);
      end
      chk("rstmid_wr_after", s_wr, 7);

      // random valids and full
      base = int'(s_wr);
      sum = 0;
      for (int i = 0; i < NR; i++) begin
         left[i] = $urandom_range(5, 30);
         sum += left[i];
      end
      rnd_mode = 1'b1;
      drive();
      run_idle(4000, "rand");
      rnd_mode = 1'b0;
      bif.wfull = 1'b0;
      drive();
      tick();
      chk("rand_wr", s_wr, base + sum);
      for (int i = 0; i < NR; i++) chk("rand_queue_empty", exp_q[i].size(), 0);

      for (int t = 0; t < 80000 && !sat_done; t++) @(posedge wclk);
      if (!sat_done) chk("sat_not_done", 0, 1);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
